// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: register-array memory, HSIZE byte-lane writes, programmable wait states.
// Optional range/alignment ERROR response enabled by defining AHB_SRAM_RANGE_ERR_EN.
module ahb_sram_slave #(
    parameter int unsigned ADDR_W      = 36,
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              HSEL,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic              HWRITE,
    input  logic [1:0]        HTRANS,
    input  logic [2:0]        HSIZE,
    input  logic [2:0]        HBURST,
    input  logic              HMASTLOCK,
    input  logic              HREADYIN,
    input  logic [DATA_W-1:0] HWDATA,
    output logic              HREADY,
    output logic [1:0]        HRESP,
    output logic [DATA_W-1:0] HRDATA
);

    localparam int unsigned NBYTES   = DATA_W / 8;
    localparam int unsigned LANE_W   = $clog2(NBYTES);
    localparam int unsigned IDX_W    = $clog2(DEPTH);
    localparam int unsigned IDX_LO   = LANE_W;
    localparam int unsigned IDX_HI   = LANE_W + IDX_W - 1;
    localparam int unsigned CNT_W    = 4;
    localparam bit          HAS_WAIT = (WAIT_STATES != 0);
    localparam int unsigned WS_LOAD  = HAS_WAIT ? (WAIT_STATES - 1) : 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    state_t             w_dest;
    logic [IDX_W-1:0]   r_idx;
    logic [LANE_W-1:0]  r_lane;
    logic               r_write;
    logic [2:0]         r_size;
    logic               r_err;
    logic [CNT_W-1:0]   r_cnt;
    logic [DATA_W-1:0]  r_mem [DEPTH];

    logic               w_accept;
    logic               w_take;
    logic               w_err;
    logic [2:0]         w_size_eff;
    logic [NBYTES-1:0]  w_be;
    logic               w_unused;

    assign w_accept = HSEL && HREADYIN && HTRANS[1];
    // Only IDLE and DATA open an address phase; a beat offered during ERR2 is dropped.
    assign w_take   = w_accept && ((r_state == ST_IDLE) || (r_state == ST_DATA));

`ifdef AHB_SRAM_RANGE_ERR_EN
    logic [2:0]        w_hsize_eff;
    logic [LANE_W-1:0] w_align_mask;

    always_comb begin
        w_hsize_eff  = (HSIZE > 3'(LANE_W)) ? 3'(LANE_W) : HSIZE;
        w_align_mask = '0;
        for (int b = 0; b < int'(LANE_W); b++) begin
            if (b < int'(w_hsize_eff)) begin
                w_align_mask[b] = 1'b1;
            end
        end
    end

    assign w_err    = (HADDR[ADDR_W-1:IDX_HI+1] != '0) ||
                      ((HADDR[LANE_W-1:0] & w_align_mask) != '0);
    assign w_unused = ^{HTRANS[0], HBURST, HMASTLOCK};
`else
    assign w_err    = 1'b0;
    assign w_unused = ^{HTRANS[0], HBURST, HMASTLOCK, HADDR[ADDR_W-1:IDX_HI+1]};
`endif

    // Byte strobes: every lane in the same size-aligned block as the start lane.
    always_comb begin
        w_size_eff = (r_size > 3'(LANE_W)) ? 3'(LANE_W) : r_size;
        w_be       = '0;
        for (int b = 0; b < int'(NBYTES); b++) begin
            if ((b >> w_size_eff) == (int'(r_lane) >> w_size_eff)) begin
                w_be[b] = 1'b1;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_dest = HAS_WAIT ? ST_WAIT : (w_err ? ST_ERR1 : ST_DATA);
        HREADY = 1'b1;
        HRESP  = 2'b00;
        HRDATA = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_take) begin
                    w_next = w_dest;
                end
            end
            ST_WAIT: begin
                HREADY = 1'b0;
                if (r_cnt == '0) begin
                    w_next = r_err ? ST_ERR1 : ST_DATA;
                end
            end
            ST_DATA: begin
                if (!r_write) begin
                    HRDATA = r_mem[r_idx];
                end
                w_next = w_take ? w_dest : ST_IDLE;
            end
            ST_ERR1: begin
                HREADY = 1'b0;
                HRESP  = 2'b01;
                w_next = ST_ERR2;
            end
            ST_ERR2: begin
                HRESP  = 2'b01;
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Address-phase capture and wait-state down-counter.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_idx   <= '0;
            r_lane  <= '0;
            r_write <= 1'b0;
            r_size  <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else if (w_take) begin
            r_idx   <= HADDR[IDX_HI:IDX_LO];
            r_lane  <= HADDR[LANE_W-1:0];
            r_write <= HWRITE;
            r_size  <= HSIZE;
            r_err   <= w_err;
            r_cnt   <= CNT_W'(WS_LOAD);
        end else if ((r_state == ST_WAIT) && (r_cnt != '0)) begin
            r_cnt   <= r_cnt - CNT_W'(1);
        end
    end

    // Write commits at the end of the DATA cycle unless reset aborts it.
    always_ff @(posedge HCLK) begin
        if (!HRESET && (r_state == ST_DATA) && r_write) begin
            for (int b = 0; b < int'(NBYTES); b++) begin
                if (w_be[b]) begin
                    r_mem[r_idx][8*b +: 8] <= HWDATA[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: directed and random AHB beats on a zero-wait and a 3-wait instance,
// checked against a byte-lane memory model.
module tb_ahb_sram_slave;

    localparam int DEP = 1024;
`ifdef AHB_SRAM_RANGE_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct {
        logic [35:0] addr;
        logic        wr;
        logic [2:0]  size;
        logic [63:0] data;
        logic        gap;
        logic        seq;
    } beat_t;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        hsel0, hsel3;
    logic [35:0] HADDR;
    logic        HWRITE;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [63:0] HWDATA;
    logic        hready0, hready3;
    logic [1:0]  hresp0, hresp3;
    logic [63:0] hrdata0, hrdata3;

    always #5 HCLK = ~HCLK;

    ahb_sram_slave #(.ADDR_W(36), .DATA_W(64), .DEPTH(DEP), .WAIT_STATES(0)) u_dut0 (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel0), .HADDR(HADDR), .HWRITE(HWRITE),
        .HTRANS(HTRANS), .HSIZE(HSIZE), .HBURST(3'b000), .HMASTLOCK(1'b0),
        .HREADYIN(hready0), .HWDATA(HWDATA), .HREADY(hready0), .HRESP(hresp0), .HRDATA(hrdata0)
    );

    ahb_sram_slave #(.ADDR_W(36), .DATA_W(64), .DEPTH(DEP), .WAIT_STATES(3)) u_dut3 (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel3), .HADDR(HADDR), .HWRITE(HWRITE),
        .HTRANS(HTRANS), .HSIZE(HSIZE), .HBURST(3'b000), .HMASTLOCK(1'b0),
        .HREADYIN(hready3), .HWDATA(HWDATA), .HREADY(hready3), .HRESP(hresp3), .HRDATA(hrdata3)
    );

    int          nchk = 0;
    int          nfail = 0;
    int          cur = 0;
    int          last_cycles = 0;
    logic [63:0] last_rd;
    logic [63:0] mm [2][DEP];
    beat_t       q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int eff_size(input logic [2:0] sz);
        return (sz > 3'd3) ? 3 : int'(sz);
    endfunction

    function automatic int widx(input logic [35:0] a);
        return int'((a >> 3) % 36'(DEP));
    endfunction

    function automatic logic exp_err(input logic [35:0] a, input logic [2:0] sz);
        logic oor;
        logic mis;
        oor = (a >= 36'(DEP * 8));
        mis = ((a % (36'd1 << eff_size(sz))) != 36'd0);
        return ERR_EN && (oor || mis);
    endfunction

    function automatic void model_write(input int d, input logic [35:0] a,
                                        input logic [2:0] sz, input logic [63:0] data);
        int nb;
        int base;
        int w;
        nb   = 1 << eff_size(sz);
        base = (int'(a % 36'd8) / nb) * nb;
        w    = widx(a);
        for (int b = base; b < base + nb; b++) begin
            mm[d][w][8*b +: 8] = data[8*b +: 8];
        end
    endfunction

    function automatic beat_t mk(input logic [35:0] a, input logic wr,
                                 input logic [2:0] sz, input logic [63:0] data);
        beat_t b;
        b.addr = a; b.wr = wr; b.size = sz; b.data = data; b.gap = 1'b0; b.seq = 1'b0;
        return b;
    endfunction

    function automatic beat_t rand_beat();
        beat_t       b;
        longint      off;
        longint      hi;
        longint      word;
        b.size = 3'($urandom_range(0, 3));
        b.wr   = 1'($urandom_range(0, 1));
        b.data = {$urandom, $urandom};
        b.gap  = ($urandom_range(0, 3) == 0);
        b.seq  = 1'($urandom_range(0, 1));
        word   = longint'($urandom_range(0, DEP - 1));
        off    = longint'($urandom_range(0, 7));
        if (!ERR_EN || ($urandom_range(0, 4) != 0)) begin
            off = (off >> b.size) << b.size;
        end
        hi     = ($urandom_range(0, 4) == 0) ? longint'($urandom_range(1, 255)) : 0;
        b.addr = 36'((hi << 13) + word * 8 + off);
        return b;
    endfunction

    // Acts as the AHB master for the queued beats on the selected instance and scores each cycle.
    task automatic run_seq();
        beat_t       dp;
        beat_t       ab;
        logic        dpv = 1'b0;
        logic        drove;
        logic        dperr;
        int          waits = 0;
        int          cyc = 0;
        int          wsx;
        logic        hr;
        logic [1:0]  hp;
        logic [63:0] hd;
        wsx = (cur == 0) ? 0 : 3;
        while ((q.size() > 0) || dpv) begin
            drove = 1'b0;
            if ((q.size() > 0) && q[0].gap) begin
                q[0].gap = 1'b0;
                HTRANS   = 2'b00;
            end else if (q.size() > 0) begin
                ab     = q[0];
                HTRANS = ab.seq ? 2'b11 : 2'b10;
                HADDR  = ab.addr;
                HWRITE = ab.wr;
                HSIZE  = ab.size;
                drove  = 1'b1;
            end else begin
                HTRANS = 2'b00;
            end
            HWDATA = (dpv && dp.wr) ? dp.data : 64'h0;
            @(negedge HCLK);
            cyc++;
            hr = (cur == 0) ? hready0 : hready3;
            hp = (cur == 0) ? hresp0  : hresp3;
            hd = (cur == 0) ? hrdata0 : hrdata3;
            if (dpv) begin
                dperr = exp_err(dp.addr, dp.size);
                if (!hr) begin
                    chk("resp_in_wait", 64'(hp), ((dperr && (waits == wsx)) ? 64'd1 : 64'd0));
                    chk("rdata_in_wait", hd, 64'h0);
                    waits++;
                end else begin
                    chk("wait_count", 64'(waits), 64'(wsx + int'(dperr)));
                    chk("resp_done", 64'(hp), dperr ? 64'd1 : 64'd0);
                    if (!dp.wr && !dperr) begin
                        chk("rdata", hd, mm[cur][widx(dp.addr)]);
                        last_rd = hd;
                    end else begin
                        chk("rdata_zero", hd, 64'h0);
                    end
                    if (dp.wr && !dperr) begin
                        model_write(cur, dp.addr, dp.size, dp.data);
                    end
                    dpv   = 1'b0;
                    waits = 0;
                end
            end else begin
                chk("idle_ready", 64'(hr), 64'd1);
                chk("idle_resp", 64'(hp), 64'd0);
                chk("idle_rdata", hd, 64'h0);
            end
            if ((waits > 20) || (cyc > 20000)) begin
                chk("wait_bound", 64'(waits), 64'(wsx + 1));
                $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
                $fatal(1, "FAIL bus stalled on dut index %0d", cur);
            end
            if (hr && drove && (hp != 2'b01)) begin
                dp  = ab;
                dpv = 1'b1;
                void'(q.pop_front());
            end
            @(posedge HCLK);
            #1;
        end
        HTRANS      = 2'b00;
        HWDATA      = 64'h0;
        last_cycles = cyc;
    endtask

    task automatic select(input int d);
        cur   = d;
        hsel0 = (d == 0);
        hsel3 = (d != 0);
    endtask

    initial begin
        logic [63:0] v0;
        logic [63:0] v1;
        HRESET = 1'b1;
        hsel0  = 1'b0;
        hsel3  = 1'b0;
        HADDR  = '0;
        HWRITE = 1'b0;
        HTRANS = 2'b00;
        HSIZE  = 3'd3;
        HWDATA = '0;
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        chk("rst_ready0", 64'(hready0), 64'd1);
        chk("rst_resp0", 64'(hresp0), 64'd0);
        chk("rst_rdata0", hrdata0, 64'h0);
        chk("rst_ready3", 64'(hready3), 64'd1);
        chk("rst_resp3", 64'(hresp3), 64'd0);
        chk("rst_rdata3", hrdata3, 64'h0);
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;

        // Known contents everywhere so every later read has a model value.
        for (int d = 0; d < 2; d++) begin
            select(d);
            for (int w = 0; w < DEP; w++) begin
                q.push_back(mk(36'(w * 8), 1'b1, 3'd3, {$urandom, $urandom}));
            end
            run_seq();
        end

        select(0);
        q.push_back(mk(36'h10, 1'b1, 3'd3, 64'h1122334455667788));
        q.push_back(mk(36'h10, 1'b0, 3'd3, 64'h0));
        run_seq();
        chk("t1_read", last_rd, 64'h1122334455667788);
        chk("t1_cycles", 64'(last_cycles), 64'd3);

        q.push_back(mk(36'h10, 1'b1, 3'd3, 64'h0));
        q.push_back(mk(36'h13, 1'b1, 3'd0, 64'h00000000AA000000));
        q.push_back(mk(36'h10, 1'b0, 3'd3, 64'h0));
        run_seq();
        chk("t2_byte", last_rd, 64'h00000000AA000000);

        v0 = {$urandom, $urandom};
        q.push_back(mk(36'h08, 1'b1, 3'd3, v0));
        q.push_back(mk(36'h08, 1'b0, 3'd3, 64'h0));
        run_seq();
        chk("t5_raw", last_rd, v0);
        chk("t5_cycles", 64'(last_cycles), 64'd3);

        q.push_back(mk(36'h0, 1'b1, 3'd3, 64'hCAFEF00DDEADBEEF));
        q.push_back(mk(36'h2000, 1'b1, 3'd3, 64'h5A5A5A5A12345678));
        q.push_back(mk(36'h0, 1'b0, 3'd3, 64'h0));
        run_seq();
        chk("t4_range", last_rd, ERR_EN ? 64'hCAFEF00DDEADBEEF : 64'h5A5A5A5A12345678);

        for (int i = 0; i < 200; i++) begin
            q.push_back(rand_beat());
        end
        run_seq();

        select(1);
        q.push_back(mk(36'h10, 1'b0, 3'd3, 64'h0));
        run_seq();
        chk("t3_cycles", 64'(last_cycles), 64'd5);

        for (int i = 0; i < 60; i++) begin
            q.push_back(rand_beat());
        end
        run_seq();

        v0 = {$urandom, $urandom};
        v1 = ~v0;
        q.push_back(mk(36'h40, 1'b1, 3'd3, v0));
        run_seq();
        HTRANS = 2'b10;
        HADDR  = 36'h40;
        HWRITE = 1'b1;
        HSIZE  = 3'd3;
        @(posedge HCLK);
        #1;
        HTRANS = 2'b00;
        HWDATA = v1;
        @(negedge HCLK);
        chk("t6_wait1", 64'(hready3), 64'd0);
        @(posedge HCLK);
        #1;
        HRESET = 1'b1;
        @(negedge HCLK);
        chk("t6_wait2", 64'(hready3), 64'd0);
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        HWDATA = 64'h0;
        @(negedge HCLK);
        chk("t6_ready", 64'(hready3), 64'd1);
        chk("t6_resp", 64'(hresp3), 64'd0);
        chk("t6_rdata", hrdata3, 64'h0);
        @(posedge HCLK);
        #1;
        q.push_back(mk(36'h40, 1'b0, 3'd3, 64'h0));
        run_seq();
        chk("t6_old", last_rd, v0);

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule
